sprite_renderer_n: RTL

//  Generalised tile-sprite renderer for the VGA path. On each start pulse it

---
 rtl/sprite_renderer_n.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/sprite_renderer_n.sv
// Tile-sprite renderer: erases each sprite at its last-drawn tile, then redraws it from the sprite ROM at its new tile.
// Erase pixels are registered on the counter edge; draw pixels one edge later, after the ROM read.
module sprite_renderer_n #(
    parameter int              NUM_SPRITES = 4,
    parameter int              TILE        = 5,
    parameter int              GX_W        = 5,
    parameter int              GY_W        = 4,
    parameter int              VX_W        = 8,
    parameter int              VY_W        = 7,
    parameter int              COLOR_W     = 12,
    parameter int              SCREEN_W    = 160,
    parameter int              SCREEN_H    = 120,
    parameter logic [COLOR_W-1:0] KEY_COLOR = 12'hF0F,
    localparam int             AW          = $clog2(NUM_SPRITES*TILE*TILE)
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    input  logic [NUM_SPRITES-1:0]      sprite_en,
    input  logic [NUM_SPRITES*GX_W-1:0] sprite_gx,
    input  logic [NUM_SPRITES*GY_W-1:0] sprite_gy,
    input  logic [COLOR_W-1:0]          bg_color,
    output logic [AW-1:0]               rom_addr,
    input  logic [COLOR_W-1:0]          rom_q,
    output logic [VX_W-1:0]             vga_x,
    output logic [VY_W-1:0]             vga_y,
    output logic [COLOR_W-1:0]          vga_color,
    output logic                        vga_plot
);

    localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int CW = (TILE > 1) ? $clog2(TILE) : 1;

    localparam logic [IW-1:0]   LP_LAST_IDX = IW'(NUM_SPRITES - 1);
    localparam logic [CW-1:0]   LP_TM1      = CW'(TILE - 1);
    localparam logic [VX_W:0]   LP_TX       = (VX_W+1)'(TILE);
    localparam logic [VY_W:0]   LP_TY       = (VY_W+1)'(TILE);
    localparam logic [VX_W:0]   LP_SW       = (VX_W+1)'(SCREEN_W);
    localparam logic [VY_W:0]   LP_SH       = (VY_W+1)'(SCREEN_H);
    localparam logic [AW-1:0]   LP_TT       = AW'(TILE*TILE);
    localparam logic [AW-1:0]   LP_TA       = AW'(TILE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ERASE = 3'd1,
        S_DRAW  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t r_state, w_next;

    logic [IW-1:0]               r_idx;
    logic [CW-1:0]               r_dx, r_dy;
    logic [NUM_SPRITES-1:0]      r_cur_en, r_prev_valid;
    logic [NUM_SPRITES*GX_W-1:0] r_cur_gx, r_prev_gx;
    logic [NUM_SPRITES*GY_W-1:0] r_cur_gy, r_prev_gy;
    logic                        r_busy, r_done;
    logic [VX_W-1:0]             r_vga_x;
    logic [VY_W-1:0]             r_vga_y;
    logic [COLOR_W-1:0]          r_vga_color;
    logic                        r_vga_plot;
    logic                        r_p_act, r_p_clip;
    logic [VX_W-1:0]             r_p_x;
    logic [VY_W-1:0]             r_p_y;

    logic            w_slot_act, w_tile_end, w_last_slot, w_clip;
    logic [GX_W-1:0] w_gx;
    logic [GY_W-1:0] w_gy;
    logic [VX_W:0]   w_px;
    logic [VY_W:0]   w_py;
    logic            w_snap, w_commit, w_erase_pix, w_draw_pix, w_count;

    // Erase walks the previous frame's tiles, draw walks the snapshot.
    assign w_slot_act  = (r_state == S_ERASE) ? r_prev_valid[r_idx] : r_cur_en[r_idx];
    assign w_gx        = (r_state == S_ERASE) ? r_prev_gx[r_idx*GX_W +: GX_W] : r_cur_gx[r_idx*GX_W +: GX_W];
    assign w_gy        = (r_state == S_ERASE) ? r_prev_gy[r_idx*GY_W +: GY_W] : r_cur_gy[r_idx*GY_W +: GY_W];
    assign w_tile_end  = !w_slot_act || ((r_dx == LP_TM1) && (r_dy == LP_TM1));
    assign w_last_slot = w_tile_end && (r_idx == '0);

    assign w_px   = (VX_W+1)'(w_gx) * LP_TX + (VX_W+1)'(r_dx);
    assign w_py   = (VY_W+1)'(w_gy) * LP_TY + (VY_W+1)'(r_dy);
    assign w_clip = (w_px >= LP_SW) || (w_py >= LP_SH);

    assign rom_addr = AW'(r_idx) * LP_TT + AW'(r_dy) * LP_TA + AW'(r_dx);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ERASE;
            S_ERASE: if (w_last_slot) w_next = S_DRAW;
            S_DRAW:  if (w_last_slot) w_next = S_FLUSH;
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_snap      = 1'b0;
        w_commit    = 1'b0;
        w_erase_pix = 1'b0;
        w_draw_pix  = 1'b0;
        w_count     = 1'b0;
        case (r_state)
            S_IDLE:  w_snap = start;
            S_ERASE: begin w_count = 1'b1; w_erase_pix = w_slot_act; end
            S_DRAW:  begin w_count = 1'b1; w_draw_pix  = w_slot_act; end
            S_DONE:  w_commit = 1'b1;
            default: ;
        endcase
    end

    // dx is the fast counter; the sprite index wraps to the top between passes.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_idx <= LP_LAST_IDX;
            r_dx  <= '0;
            r_dy  <= '0;
        end else if (!w_count) begin
            r_idx <= LP_LAST_IDX;
            r_dx  <= '0;
            r_dy  <= '0;
        end else if (w_tile_end) begin
            r_idx <= (r_idx == '0) ? LP_LAST_IDX : r_idx - 1'b1;
            r_dx  <= '0;
            r_dy  <= '0;
        end else if (r_dx == LP_TM1) begin
            r_dx <= '0;
            r_dy <= r_dy + 1'b1;
        end else begin
            r_dx <= r_dx + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cur_en     <= '0;
            r_cur_gx     <= '0;
            r_cur_gy     <= '0;
            r_prev_valid <= '0;
            r_prev_gx    <= '0;
            r_prev_gy    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_snap) begin
                r_cur_en <= sprite_en;
                r_cur_gx <= sprite_gx;
                r_cur_gy <= sprite_gy;
                r_busy   <= 1'b1;
            end
            if (w_commit) begin
                r_prev_valid <= r_cur_en;
                r_prev_gx    <= r_cur_gx;
                r_prev_gy    <= r_cur_gy;
                r_busy       <= 1'b0;
            end
        end
    end

    // Draw pixels wait one cycle in r_p_* for rom_q; FLUSH drains the last one.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_p_act     <= 1'b0;
            r_p_clip    <= 1'b0;
            r_p_x       <= '0;
            r_p_y       <= '0;
            r_vga_x     <= '0;
            r_vga_y     <= '0;
            r_vga_color <= '0;
            r_vga_plot  <= 1'b0;
        end else begin
            r_p_act  <= w_draw_pix;
            r_p_clip <= w_clip;
            r_p_x    <= w_px[VX_W-1:0];
            r_p_y    <= w_py[VY_W-1:0];
            if (w_erase_pix) begin
                r_vga_x     <= w_px[VX_W-1:0];
                r_vga_y     <= w_py[VY_W-1:0];
                r_vga_color <= bg_color;
                r_vga_plot  <= !w_clip;
            end else if (r_p_act) begin
                r_vga_x     <= r_p_x;
                r_vga_y     <= r_p_y;
                r_vga_color <= rom_q;
                r_vga_plot  <= !r_p_clip && (rom_q != KEY_COLOR);
            end else begin
                r_vga_plot  <= 1'b0;
            end
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign vga_x     = r_vga_x;
    assign vga_y     = r_vga_y;
    assign vga_color = r_vga_color;
    assign vga_plot  = r_vga_plot;

endmodule
